// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - full-duplex 8N1 UART with valid/ready byte ports
module uart_transceiver #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    input  logic       serial_in,
    output logic       serial_out
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] SYM_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] MID_LAST = CW'(SAMPLE_TIME - 1);

    // ---------------- transmitter ----------------
    logic          tx_active;
    logic [8:0]    tx_shift;
    logic [3:0]    tx_bit_cnt;
    logic [CW-1:0] tx_clk_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            serial_out    <= 1'b1;
            data_in_ready <= 1'b0;
            tx_active     <= 1'b0;
            tx_shift      <= '0;
            tx_bit_cnt    <= '0;
            tx_clk_cnt    <= '0;
        end else if (!tx_active) begin
            if (data_in_ready && data_in_valid) begin
                // start bit goes out immediately; stop bit rides in tx_shift[8]
                tx_active     <= 1'b1;
                data_in_ready <= 1'b0;
                serial_out    <= 1'b0;
                tx_shift      <= {1'b1, data_in};
                tx_bit_cnt    <= '0;
                tx_clk_cnt    <= '0;
            end else begin
                data_in_ready <= 1'b1;
            end
        end else if (tx_clk_cnt == SYM_LAST) begin
            tx_clk_cnt <= '0;
            if (tx_bit_cnt == 4'd9) begin
                tx_active     <= 1'b0;
                data_in_ready <= 1'b1;
                serial_out    <= 1'b1;
            end else begin
                tx_bit_cnt <= tx_bit_cnt + 4'd1;
                serial_out <= tx_shift[0];
                tx_shift   <= {1'b1, tx_shift[8:1]};
            end
        end else begin
            tx_clk_cnt <= tx_clk_cnt + CW'(1);
        end
    end

    // ---------------- receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state;
    rx_state_t     rx_state_next;
    logic          rx_sync1;
    logic          rx_line;
    logic [CW-1:0] rx_clk_cnt;
    logic [2:0]    rx_bit_cnt;
    logic [7:0]    rx_shift;
    logic          rx_mid;
    logic          rx_done;

    always_comb begin
        rx_state_next = rx_state;
        rx_done       = 1'b0;
        // start bit is checked half a symbol in; every later sample is one symbol on
        rx_mid = (rx_state == RX_START) ? (rx_clk_cnt == MID_LAST) : (rx_clk_cnt == SYM_LAST);
        case (rx_state)
            RX_IDLE:  if (!rx_line) rx_state_next = RX_START;
            RX_START: if (rx_mid) rx_state_next = rx_line ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_mid && rx_bit_cnt == 3'd7) rx_state_next = RX_STOP;
            RX_STOP: begin
                if (rx_mid) begin
                    rx_state_next = RX_IDLE;
                    rx_done       = rx_line;
                end
            end
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_sync1       <= 1'b1;
            rx_line        <= 1'b1;
            rx_state       <= RX_IDLE;
            rx_clk_cnt     <= '0;
            rx_bit_cnt     <= '0;
            rx_shift       <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            rx_sync1 <= serial_in;
            rx_line  <= rx_sync1;
            rx_state <= rx_state_next;

            if (rx_state == RX_IDLE || rx_mid) rx_clk_cnt <= '0;
            else                               rx_clk_cnt <= rx_clk_cnt + CW'(1);

            if (rx_state != RX_DATA) begin
                rx_bit_cnt <= '0;
            end else if (rx_mid) begin
                rx_bit_cnt <= rx_bit_cnt + 3'd1;
                rx_shift   <= {rx_line, rx_shift[7:1]};
            end

            // a fresh byte beats a simultaneous consume and overwrites an unread one
            if (rx_done) begin
                data_out       <= rx_shift;
                data_out_valid <= 1'b1;
            end else if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - self-checking bench for uart_transceiver
`timescale 1ns/1ps
module tb_uart_transceiver;
    localparam int SYM_D = 125_000_000 / 115_200;
    localparam int FS    = 1_600_000;
    localparam int BS    = 100_000;
    localparam int SYM_S = FS / BS;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [7:0] d_din;  logic d_dv;  wire d_rdy;  wire [7:0] d_dout;  wire d_dov;  logic d_dor;  logic d_line;  wire d_so;
    logic [7:0] a_din;  logic a_dv;  wire a_rdy;  wire [7:0] a_dout;  wire a_dov;  logic a_dor;  wire a_so;
    logic [7:0] b_din;  logic b_dv;  wire b_rdy;  wire [7:0] b_dout;  wire b_dov;  logic b_dor;  wire b_so;
    logic b_inj;  logic b_line;
    wire  b_si = b_inj ? b_line : a_so;

    uart_transceiver dut (
        .clk(clk), .reset(reset), .data_in(d_din), .data_in_valid(d_dv), .data_in_ready(d_rdy),
        .data_out(d_dout), .data_out_valid(d_dov), .data_out_ready(d_dor),
        .serial_in(d_line), .serial_out(d_so));

    uart_transceiver #(.CLOCK_FREQ(FS), .BAUD_RATE(BS)) ua (
        .clk(clk), .reset(reset), .data_in(a_din), .data_in_valid(a_dv), .data_in_ready(a_rdy),
        .data_out(a_dout), .data_out_valid(a_dov), .data_out_ready(a_dor),
        .serial_in(b_so), .serial_out(a_so));

    uart_transceiver #(.CLOCK_FREQ(FS), .BAUD_RATE(BS)) ub (
        .clk(clk), .reset(reset), .data_in(b_din), .data_in_valid(b_dv), .data_in_ready(b_rdy),
        .data_out(b_dout), .data_out_valid(b_dov), .data_out_ready(b_dor),
        .serial_in(b_si), .serial_out(b_so));

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    always @(negedge clk) if (b_dov && b_dor) got.push_back(b_dout);

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } tx_vec_t;
    tx_vec_t tv [5];

    logic [7:0] msg [14] = '{8'h6A, 8'h61, 8'h6C, 8'h20, 8'h31, 8'h30, 8'h30,
                             8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h71};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic so_of(input int w);
        return (w == 0) ? d_so : a_so;
    endfunction

    function automatic logic rdy_of(input int w);
        return (w == 0) ? d_rdy : a_rdy;
    endfunction

    task automatic set_tx(input int w, input logic [7:0] d, input logic v);
        if (w == 0) begin d_din = d; d_dv = v; end
        else        begin a_din = d; a_dv = v; end
    endtask

    task automatic wait_ready(input int w, input int sym, input string name, output bit ok);
        int waited = 0;
        while (rdy_of(w) !== 1'b1 && waited < 20 * sym) begin
            tick(1);
            waited++;
        end
        ok = (rdy_of(w) === 1'b1);
        if (!ok) chk({name, " ready timeout"}, {31'd0, rdy_of(w)}, 32'd1);
    endtask

    task automatic send(input int w, input int sym, input logic [7:0] d);
        bit ok;
        wait_ready(w, sym, "send", ok);
        if (ok) begin
            set_tx(w, d, 1'b1);
            tick(1);
            set_tx(w, 8'h00, 1'b0);
        end
    endtask

    // accepts one byte and checks every cycle of the ten-bit frame plus ready timing
    task automatic tx_frame(input int w, input int sym, input logic [7:0] d, input logic [9:0] frame, input string name);
        bit ok;
        int bad;
        wait_ready(w, sym, name, ok);
        if (!ok) return;
        set_tx(w, d, 1'b1);
        tick(1);
        set_tx(w, ~d, 1'b0);
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int c = 0; c < sym; c++) begin
                if (so_of(w) !== frame[k] || rdy_of(w) !== 1'b0) bad++;
                tick(1);
            end
            chk($sformatf("%s bit%0d bad cycles", name, k), bad, 0);
        end
        chk({name, " ready after frame"}, {31'd0, rdy_of(w)}, 32'd1);
        chk({name, " idle line after frame"}, {31'd0, so_of(w)}, 32'd1);
    endtask

    task automatic set_line(input int w, input logic v);
        if (w == 0) d_line = v;
        else        b_line = v;
    endtask

    // bit-banged frame; a zero stop bit is cut short so the following idle is clean
    task automatic bb_frame(input int w, input int sym, input logic [7:0] d, input bit stop);
        set_line(w, 1'b0);
        tick(sym);
        for (int k = 0; k < 8; k++) begin
            set_line(w, d[k]);
            tick(sym);
        end
        set_line(w, stop);
        tick(stop ? sym : (sym * 3) / 4);
        set_line(w, 1'b1);
        tick(2 * sym);
    endtask

    initial begin
        logic [7:0] rd;
        bit         st;
        logic [7:0] md;
        logic       mv;

        tv[0] = '{8'h6A, 10'b1011010100};
        tv[1] = '{8'h00, 10'b1000000000};
        tv[2] = '{8'hFF, 10'b1111111110};
        tv[3] = '{8'h81, 10'b1100000010};
        tv[4] = '{8'hA5, 10'b1101001010};

        reset = 1'b0;
        d_din = 8'h00; d_dv = 1'b0; d_dor = 1'b0; d_line = 1'b1;
        a_din = 8'h00; a_dv = 1'b0; a_dor = 1'b1;
        b_din = 8'h00; b_dv = 1'b0; b_dor = 1'b1;
        b_inj = 1'b0;  b_line = 1'b1;

        tick(30);
        chk("reset serial_out", {31'd0, d_so}, 32'd1);
        chk("reset data_in_ready", {31'd0, d_rdy}, 32'd0);
        chk("reset data_out_valid", {31'd0, d_dov}, 32'd0);
        chk("reset data_out", {24'd0, d_dout}, 32'd0);
        chk("reset small ready", {31'd0, a_rdy}, 32'd0);
        reset = 1'b1;
        tick(1);
        chk("ready after release", {31'd0, d_rdy}, 32'd1);

        for (int i = 0; i < 4; i++)
            tx_frame(1, SYM_S, tv[i].data, tv[i].frame, $sformatf("tx table %0d", i));

        tx_frame(0, SYM_D, tv[0].data, tv[0].frame, "tx 6A full rate");

        tick(4 * SYM_S);
        got.delete();
        exp_q.delete();
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(msg[i]);
            send(1, SYM_S, msg[i]);
        end
        for (int i = 0; i < 16; i++) begin
            rd = 8'($urandom);
            exp_q.push_back(rd);
            send(1, SYM_S, rd);
        end
        tick(30 * SYM_S);
        chk("loopback count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) chk($sformatf("loopback byte %0d", i), {24'd0, got[i]}, {24'd0, exp_q[i]});
        end

        b_dor = 1'b0;
        send(1, SYM_S, 8'h55);
        tick(11 * SYM_S + 8);
        chk("bp valid after 55", {31'd0, b_dov}, 32'd1);
        chk("bp data 55", {24'd0, b_dout}, 32'h55);
        send(1, SYM_S, 8'hA3);
        tick(11 * SYM_S + 8);
        chk("bp valid after A3", {31'd0, b_dov}, 32'd1);
        chk("bp data A3 overwrite", {24'd0, b_dout}, 32'hA3);
        b_dor = 1'b1;
        tick(1);
        b_dor = 1'b0;
        chk("bp valid after consume", {31'd0, b_dov}, 32'd0);

        b_inj = 1'b1;
        md = 8'hA3;
        mv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rd = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            bb_frame(1, SYM_S, rd, st);
            if (st) begin md = rd; mv = 1'b1; end
            chk($sformatf("rand rx %0d valid", i), {31'd0, b_dov}, {31'd0, mv});
            chk($sformatf("rand rx %0d data", i), {24'd0, b_dout}, {24'd0, md});
        end
        b_inj = 1'b0;

        d_line = 1'b0;
        tick(300);
        d_line = 1'b1;
        tick(2 * SYM_D);
        chk("glitch no byte", {31'd0, d_dov}, 32'd0);
        bb_frame(0, SYM_D, 8'h5A, 1'b0);
        chk("framing error no byte", {31'd0, d_dov}, 32'd0);
        bb_frame(0, SYM_D, 8'hC5, 1'b1);
        chk("full rate rx valid", {31'd0, d_dov}, 32'd1);
        chk("full rate rx data", {24'd0, d_dout}, 32'hC5);

        send(0, SYM_D, 8'hA5);
        tick(4 * SYM_D + SYM_D / 2 - 1);
        chk("mid bit4 value", {31'd0, d_so}, 32'd0);
        reset = 1'b0;
        tick(1);
        chk("abort serial_out", {31'd0, d_so}, 32'd1);
        chk("abort ready low", {31'd0, d_rdy}, 32'd0);
        chk("abort rx valid cleared", {31'd0, d_dov}, 32'd0);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("ready after abort release", {31'd0, d_rdy}, 32'd1);
        tx_frame(0, SYM_D, tv[4].data, tv[4].frame, "tx A5 after abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
